// File: rtl/mips32_fetch_unit.sv
`default_nettype none
// ============================================================================
// mips32_fetch_unit : MIPS32 instruction fetch with req/ack imem port,
//                     prefetch FIFO, branch/jump redirect and bad-PC flag.
// Revision 1.0
// ============================================================================
module mips32_fetch_unit #(
  parameter int          ADDR_BITS  = 10,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req,
  output logic [ADDR_BITS-3:0] imem_addr,
  input  logic                 imem_ack,
  input  logic [31:0]          imem_rdata,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [31:0]          inst,
  output logic [31:0]          inst_pc,
  output logic [31:0]          inst_pc4,
  output logic                 invalid_pc
);

  localparam int               PTR_W   = $clog2(FIFO_DEPTH);
  localparam int               CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t           state;
  logic [31:0]      fpc;
  logic [31:0]      fpc_plus4;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [31:0]      q_inst [FIFO_DEPTH];
  logic [31:0]      q_pc   [FIFO_DEPTH];
  logic [31:0]      q_pc4  [FIFO_DEPTH];
  logic             push;
  logic             pop;

  // A fetch address is usable only if word aligned and inside the memory span.
  function automatic logic pc_ok(input logic [31:0] p);
    return (p[1:0] == 2'b00) && ((p >> ADDR_BITS) == 32'd0);
  endfunction

  assign fpc_plus4  = fpc + 32'd4;
  assign push       = (state == ST_REQ) && imem_ack && !redirect;
  assign pop        = inst_valid && inst_ready && !redirect;
  assign count_nxt  = count + CNT_W'(push) - CNT_W'(pop);

  assign imem_addr  = fpc[ADDR_BITS-1:2];
  assign inst_valid = (count != '0);
  assign inst       = q_inst[rd_ptr];
  assign inst_pc    = q_pc[rd_ptr];
  assign inst_pc4   = q_pc4[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      imem_req   <= 1'b0;
      fpc        <= RESET_PC;
      invalid_pc <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        q_inst[i] <= '0;
        q_pc[i]   <= '0;
        q_pc4[i]  <= '0;
      end
    end else if (redirect) begin
      // Flush wins over any same-cycle push or pop; in-flight request is aborted.
      fpc        <= redirect_pc;
      invalid_pc <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      if (pc_ok(redirect_pc)) begin
        state    <= ST_REQ;
        imem_req <= 1'b1;
      end else begin
        state    <= ST_FAULT;
        imem_req <= 1'b0;
      end
    end else begin
      if (push) begin
        q_inst[wr_ptr] <= imem_rdata;
        q_pc[wr_ptr]   <= fpc;
        q_pc4[wr_ptr]  <= fpc_plus4;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nxt;

      case (state)
        ST_IDLE: begin
          if (!pc_ok(fpc)) begin
            state <= ST_FAULT;
          end else if (count < DEPTH_C) begin
            state    <= ST_REQ;
            imem_req <= 1'b1;
          end
        end
        ST_REQ: begin
          // Keep requesting only while a free slot is guaranteed for the next word.
          if (imem_ack) begin
            fpc <= fpc_plus4;
            if (!((count_nxt < DEPTH_C) && pc_ok(fpc_plus4))) begin
              state    <= ST_IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        ST_FAULT: begin
          invalid_pc <= 1'b1;
        end
        default: begin
          state    <= ST_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst && push) begin
      assert (count < DEPTH_C);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips32_fetch_unit.sv
`default_nettype none
// Testbench for mips32_fetch_unit: table-driven fetch sequences plus
// hand-written redirect, fault, address-boundary and async-reset sequences.
module tb_mips32_fetch_unit;

  localparam int AW = 10;

  logic          clk;
  logic          rst;
  logic          imem_req;
  logic [AW-3:0] imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          inst_valid;
  logic          inst_ready;
  logic [31:0]   inst;
  logic [31:0]   inst_pc;
  logic [31:0]   inst_pc4;
  logic          invalid_pc;

  mips32_fetch_unit #(
    .ADDR_BITS  (AW),
    .FIFO_DEPTH (2),
    .RESET_PC   (32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_pc4    (inst_pc4),
    .invalid_pc  (invalid_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  int          wait_states;
  int          wcnt;
  int          n_cmp;
  int          n_err;

  // Memory responder: acks after wait_states idle request cycles.
  always @(negedge clk) begin
    if (!rst || !imem_req) begin
      imem_ack = 1'b0;
      wcnt     = 0;
    end else if (wcnt == wait_states) begin
      imem_ack   = 1'b1;
      imem_rdata = mem[imem_addr];
      wcnt       = 0;
    end else begin
      imem_ack = 1'b0;
      wcnt     = wcnt + 1;
    end
  end

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return 32'h2008_0001 + (pc >> 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    chk({tag, " valid"}, {31'd0, inst_valid}, 32'd1);
    chk({tag, " pc"}, inst_pc, pc);
    chk({tag, " pc4"}, inst_pc4, pc + 32'd4);
    chk({tag, " inst"}, inst, word_at(pc));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    chk("rst req", {31'd0, imem_req}, 32'd0);
    chk("rst valid", {31'd0, inst_valid}, 32'd0);
    chk("rst invalid_pc", {31'd0, invalid_pc}, 32'd0);
    chk("rst inst", inst, 32'd0);
    chk("rst inst_pc", inst_pc, 32'd0);
    chk("rst inst_pc4", inst_pc4, 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b1;
  endtask

  typedef struct {
    bit          reset_first;
    int          ws;
    bit          ready;
    bit          exp_req;
    logic [7:0]  exp_addr;
    bit          exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input int ws, input bit rdy, input bit req,
                     input logic [7:0] addr, input bit v, input logic [31:0] pc);
    vec_t e;
    e.reset_first = r;
    e.ws          = ws;
    e.ready       = rdy;
    e.exp_req     = req;
    e.exp_addr    = addr;
    e.exp_valid   = v;
    e.exp_pc      = pc;
    vecs.push_back(e);
  endtask

  initial begin
    rst         = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'd0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    inst_ready  = 1'b0;
    wait_states = 0;
    wcnt        = 0;
    n_cmp       = 0;
    n_err       = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h2008_0001 + i;

    // Zero-wait streaming: one instruction per cycle.
    add(1, 0, 1, 1, 8'd0, 0, 32'h0);
    add(0, 0, 1, 1, 8'd1, 1, 32'h0);
    add(0, 0, 1, 1, 8'd2, 1, 32'h4);
    add(0, 0, 1, 1, 8'd3, 1, 32'h8);
    add(0, 0, 1, 1, 8'd4, 1, 32'hC);
    // Three wait states: request held, one word per four cycles.
    add(1, 3, 1, 1, 8'd0, 0, 32'h0);
    add(0, 3, 1, 1, 8'd0, 0, 32'h0);
    add(0, 3, 1, 1, 8'd0, 0, 32'h0);
    add(0, 3, 1, 1, 8'd0, 0, 32'h0);
    add(0, 3, 1, 1, 8'd1, 1, 32'h0);
    add(0, 3, 1, 1, 8'd1, 0, 32'h0);
    add(0, 3, 1, 1, 8'd1, 0, 32'h0);
    add(0, 3, 1, 1, 8'd1, 0, 32'h0);
    add(0, 3, 1, 1, 8'd2, 1, 32'h4);
    add(0, 3, 1, 1, 8'd2, 0, 32'h0);
    add(0, 3, 1, 1, 8'd2, 0, 32'h0);
    add(0, 3, 1, 1, 8'd2, 0, 32'h0);
    add(0, 3, 1, 1, 8'd3, 1, 32'h8);
    // Decode stalled for ten cycles: FIFO fills to two and fetch pauses.
    add(1, 0, 0, 1, 8'd0, 0, 32'h0);
    add(0, 0, 0, 1, 8'd1, 1, 32'h0);
    for (int i = 0; i < 8; i++) add(0, 0, 0, 0, 8'd2, 1, 32'h0);
    add(0, 0, 1, 0, 8'd2, 1, 32'h4);
    add(0, 0, 1, 1, 8'd2, 0, 32'h0);
    add(0, 0, 1, 1, 8'd3, 1, 32'h8);

    foreach (vecs[i]) begin
      if (vecs[i].reset_first) begin
        wait_states = vecs[i].ws;
        inst_ready  = vecs[i].ready;
        do_reset();
      end
      inst_ready = vecs[i].ready;
      step();
      chk($sformatf("vec%0d req", i), {31'd0, imem_req}, {31'd0, vecs[i].exp_req});
      if (vecs[i].exp_req) chk($sformatf("vec%0d addr", i), {24'd0, imem_addr}, {24'd0, vecs[i].exp_addr});
      chk($sformatf("vec%0d valid", i), {31'd0, inst_valid}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) check_head($sformatf("vec%0d", i), vecs[i].exp_pc);
    end

    // Redirect with a same-cycle ack, then misaligned redirect, then recovery.
    wait_states = 0;
    inst_ready  = 1'b1;
    do_reset();
    step(); step(); step();
    chk("pre-redir addr", {24'd0, imem_addr}, 32'd2);
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    chk("redir flush", {31'd0, inst_valid}, 32'd0);
    chk("redir req", {31'd0, imem_req}, 32'd1);
    chk("redir addr", {24'd0, imem_addr}, 32'h10);
    step();
    check_head("redir head", 32'h40);
    redirect = 1'b1; redirect_pc = 32'h42;
    step();
    redirect = 1'b0;
    chk("mis req", {31'd0, imem_req}, 32'd0);
    chk("mis valid", {31'd0, inst_valid}, 32'd0);
    chk("mis flag early", {31'd0, invalid_pc}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mis flag", {31'd0, invalid_pc}, 32'd1);
      chk("mis no req", {31'd0, imem_req}, 32'd0);
      chk("mis no valid", {31'd0, inst_valid}, 32'd0);
    end
    redirect = 1'b1; redirect_pc = 32'h80;
    step();
    redirect = 1'b0;
    chk("recover flag", {31'd0, invalid_pc}, 32'd0);
    chk("recover req", {31'd0, imem_req}, 32'd1);
    chk("recover addr", {24'd0, imem_addr}, 32'h20);
    step();
    check_head("recover head", 32'h80);

    // Sequential walk to the top of memory; increment past it faults.
    do_reset();
    step();
    chk("walk first addr", {24'd0, imem_addr}, 32'd0);
    for (int k = 2; k <= 257; k++) begin
      step();
      chk($sformatf("walk%0d valid", k), {31'd0, inst_valid}, 32'd1);
      chk($sformatf("walk%0d pc", k), inst_pc, 32'(4 * (k - 2)));
    end
    check_head("walk last", 32'h3FC);
    chk("walk end req", {31'd0, imem_req}, 32'd0);
    chk("walk flag pre", {31'd0, invalid_pc}, 32'd0);
    step();
    chk("walk drained", {31'd0, inst_valid}, 32'd0);
    chk("walk fault req", {31'd0, imem_req}, 32'd0);
    step();
    chk("walk flag", {31'd0, invalid_pc}, 32'd1);

    // Reset asserted while a request is outstanding.
    do_reset();
    step(); step(); step();
    chk("midrst req before", {31'd0, imem_req}, 32'd1);
    #3;
    rst = 1'b0;
    #1;
    chk("midrst req drop", {31'd0, imem_req}, 32'd0);
    chk("midrst valid", {31'd0, inst_valid}, 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    step();
    chk("restart req", {31'd0, imem_req}, 32'd1);
    chk("restart addr", {24'd0, imem_addr}, 32'd0);
    step();
    check_head("restart head", 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
